// File: rtl/mult_seq_n_pkg.sv
// Shared constants for the iterative shift-add multiplier: FSM state encoding
// and the default data-path width.
package mult_seq_n_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10
  } state_e;

  localparam int DEF_WIDTH = 32;

endpackage

// File: rtl/mult_seq_n_twos_neg.sv
// Conditional two's-complement negation: Q = EN ? -D : D (purely combinational).
module twos_neg_n
  import mult_seq_n_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             EN,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  assign Q = EN ? (~D + WIDTH'(1)) : D;

endmodule

// File: rtl/mult_seq_n.sv
// Iterative shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, one iteration per
// clock. Signed mode works on magnitudes and negates the product at the end.
module mult_seq_n
  import mult_seq_n_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             SIGNED,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             BUSY,
  output logic             DONE
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_e               state_q, state_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     mcnd_q, mcnd_d;
  logic                 neg_q, neg_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [WIDTH-1:0]     a_mag_s, b_mag_s;
  logic [2*WIDTH-1:0]   res_s;
  logic [WIDTH:0]       sum_s;

  twos_neg_n #(.WIDTH(WIDTH)) u_neg_a (
    .EN (SIGNED & A[WIDTH-1]),
    .D  (A),
    .Q  (a_mag_s)
  );

  twos_neg_n #(.WIDTH(WIDTH)) u_neg_b (
    .EN (SIGNED & B[WIDTH-1]),
    .D  (B),
    .Q  (b_mag_s)
  );

  twos_neg_n #(.WIDTH(2*WIDTH)) u_neg_res (
    .EN (neg_q),
    .D  (acc_q),
    .Q  (res_s)
  );

  // Next-state and data-path update for IDLE/RUN/FIX
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mcnd_d  = mcnd_q;
    neg_d   = neg_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    // Sum keeps the carry so the shift brings it into the accumulator MSB
    sum_s   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
              {1'b0, (acc_q[0] ? mcnd_q : {WIDTH{1'b0}})};
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          mcnd_d  = a_mag_s;
          acc_d   = {{WIDTH{1'b0}}, b_mag_s};
          neg_d   = SIGNED & (A[WIDTH-1] ^ B[WIDTH-1]);
          cnt_d   = {CNT_W{1'b0}};
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        acc_d = {sum_s, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = ST_FIX;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FIX: begin
        {hi_d, lo_d} = res_s;
        done_d       = 1'b1;
        busy_d       = 1'b0;
        state_d      = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      mcnd_q  <= '0;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mcnd_q  <= mcnd_d;
      neg_q   <= neg_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign HI   = hi_q;
  assign LO   = lo_q;
  assign BUSY = busy_q;
  assign DONE = done_q;

endmodule

// File: tb/tb_mult_seq_n.sv
// Self-checking bench for mult_seq_n at WIDTH=32 and WIDTH=8: directed cases
// plus randomized operations compared against an arithmetic product model.
module tb_mult_seq_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start32, sgn32, busy32, done32;
  logic [31:0] a32, b32, hi32, lo32;
  logic        start8, sgn8, busy8, done8;
  logic [7:0]  a8, b8, hi8, lo8;

  int checks   = 0;
  int failures = 0;

  mult_seq_n #(.WIDTH(32)) dut32 (
    .CLK(clk), .RST(rst_n), .START(start32), .SIGNED(sgn32), .A(a32), .B(b32),
    .HI(hi32), .LO(lo32), .BUSY(busy32), .DONE(done32)
  );

  mult_seq_n #(.WIDTH(8)) dut8 (
    .CLK(clk), .RST(rst_n), .START(start8), .SIGNED(sgn8), .A(a8), .B(b8),
    .HI(hi8), .LO(lo8), .BUSY(busy8), .DONE(done8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: integer product of the operands as interpreted by the mode
  function automatic logic [63:0] model(input bit w8, input bit sgn,
                                        input logic [31:0] a, input logic [31:0] b);
    longint ea, eb;
    logic [63:0] p;
    logic [7:0] a_lo, b_lo;
    a_lo = a[7:0];
    b_lo = b[7:0];
    if (w8) begin
      ea = sgn ? longint'($signed(a_lo)) : longint'(a_lo);
      eb = sgn ? longint'($signed(b_lo)) : longint'(b_lo);
    end else begin
      ea = sgn ? longint'($signed(a)) : longint'(a);
      eb = sgn ? longint'($signed(b)) : longint'(b);
    end
    p = 64'(ea * eb);
    if (w8) p = p & 64'h0000_0000_0000_FFFF;
    return p;
  endfunction

  function automatic logic [63:0] prod_obs(input bit w8);
    return w8 ? {48'h0, hi8, lo8} : {hi32, lo32};
  endfunction

  function automatic logic busy_obs(input bit w8);
    return w8 ? busy8 : busy32;
  endfunction

  function automatic logic done_obs(input bit w8);
    return w8 ? done8 : done32;
  endfunction

  task automatic drive(input bit w8, input bit st, input bit sgn,
                       input logic [31:0] a, input logic [31:0] b);
    if (w8) begin
      start8 = st; sgn8 = sgn; a8 = a[7:0]; b8 = b[7:0];
    end else begin
      start32 = st; sgn32 = sgn; a32 = a; b32 = b;
    end
  endtask

  // One-cycle START pulse; operands are scrambled right after the accept edge
  task automatic start_op(input bit w8, input bit sgn, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    drive(w8, 1'b1, sgn, a, b);
    @(negedge clk);
    drive(w8, 1'b0, 1'($urandom_range(1, 0)), $urandom, $urandom);
    check("accept_busy", 64'(busy_obs(w8)), 64'd1);
  endtask

  // Waits (bounded) for DONE; checks latency, BUSY held and HI/LO held meanwhile
  task automatic wait_done(input bit w8, input int exp_cyc, input string tag);
    int n = 0;
    bit hold_ok = 1'b1;
    bit busy_ok = 1'b1;
    logic [63:0] prev;
    prev = prod_obs(w8);
    while (done_obs(w8) !== 1'b1 && n < exp_cyc + 8) begin
      @(negedge clk);
      n++;
      if (done_obs(w8) !== 1'b1) begin
        if (prod_obs(w8) !== prev) hold_ok = 1'b0;
        if (busy_obs(w8) !== 1'b1) busy_ok = 1'b0;
      end
    end
    check({tag, "_latency"}, 64'(n), 64'(exp_cyc));
    check({tag, "_hold"}, 64'(hold_ok), 64'd1);
    check({tag, "_busy_run"}, 64'(busy_ok), 64'd1);
    check({tag, "_busy_done"}, 64'(busy_obs(w8)), 64'd0);
  endtask

  task automatic run_op(input bit w8, input bit sgn, input logic [31:0] a,
                        input logic [31:0] b, input string tag, output logic [63:0] res);
    start_op(w8, sgn, a, b);
    wait_done(w8, (w8 ? 8 : 32) + 1, tag);
    res = prod_obs(w8);
    check({tag, "_model"}, res, model(w8, sgn, a, b));
  endtask

  task automatic quiet(input bit w8, input int ncyc, input string tag);
    int extra = 0;
    repeat (ncyc) begin
      @(negedge clk);
      if (done_obs(w8) === 1'b1) extra++;
    end
    check(tag, 64'(extra), 64'd0);
  endtask

  initial begin
    logic [63:0] r;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (2) @(negedge clk);
    check("rst_prod32", prod_obs(1'b0), 64'd0);
    check("rst_busy32", 64'(busy32), 64'd0);
    check("rst_done32", 64'(done32), 64'd0);
    check("rst_prod8", prod_obs(1'b1), 64'd0);
    check("rst_busy8", 64'(busy8), 64'd0);
    rst_n = 1'b1;

    // Basic unsigned, signed and extreme-operand cases at WIDTH=32
    run_op(1'b0, 1'b0, 32'd7, 32'd6, "s1", r);
    check("s1_val", r, 64'h0000_0000_0000_002A);
    @(negedge clk);
    check("s1_done_pulse", 64'(done32), 64'd0);
    run_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "s2u", r);
    check("s2u_val", r, 64'hFFFF_FFFE_0000_0001);
    run_op(1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "s2s", r);
    check("s2s_val", r, 64'h0000_0000_0000_0001);
    run_op(1'b0, 1'b1, 32'hFFFF_FFFD, 32'd5, "s3a", r);
    check("s3a_val", r, 64'hFFFF_FFFF_FFFF_FFF1);
    run_op(1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, "s3b", r);
    check("s3b_val", r, 64'h4000_0000_0000_0000);

    // START while busy is ignored
    start_op(1'b0, 1'b0, 32'd3, 32'd4);
    repeat (9) @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 32'd9, 32'd9);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    wait_done(1'b0, 33 - 10, "s4");
    check("s4_val", prod_obs(1'b0), 64'h0C);
    quiet(1'b0, 40, "s4_no_second_done");
    check("s4_val_after", prod_obs(1'b0), 64'h0C);
    check("s4_idle", 64'(busy32), 64'd0);

    // Reset mid-operation aborts
    start_op(1'b0, 1'b0, 32'd5, 32'd5);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("s5_prod", prod_obs(1'b0), 64'd0);
    check("s5_busy", 64'(busy32), 64'd0);
    check("s5_done", 64'(done32), 64'd0);
    quiet(1'b0, 40, "s5_no_done");
    run_op(1'b0, 1'b0, 32'd2, 32'd3, "s5b", r);
    check("s5b_val", r, 64'd6);

    // Back-to-back: START in the DONE cycle is accepted, old result held
    run_op(1'b0, 1'b0, 32'd7, 32'd6, "s6a", r);
    drive(1'b0, 1'b1, 1'b0, 32'd2, 32'd8);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    check("s6_accept_busy", 64'(busy32), 64'd1);
    check("s6_old_held", prod_obs(1'b0), 64'h2A);
    wait_done(1'b0, 33, "s6b");
    check("s6b_val", prod_obs(1'b0), 64'h10);

    // START coinciding with the FIX edge is ignored
    start_op(1'b0, 1'b0, 32'd1, 32'd1);
    repeat (32) @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 32'd3, 32'd3);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    check("s7_done", 64'(done32), 64'd1);
    check("s7_val", prod_obs(1'b0), 64'd1);
    @(negedge clk);
    check("s7_not_accepted", 64'(busy32), 64'd0);
    quiet(1'b0, 40, "s7_no_done");

    // WIDTH=8 variants
    run_op(1'b1, 1'b0, 32'd7, 32'd6, "w8_1", r);
    check("w8_1_val", r, 64'h002A);
    run_op(1'b1, 1'b0, 32'hFF, 32'hFF, "w8_2u", r);
    check("w8_2u_val", r, 64'hFE01);
    run_op(1'b1, 1'b1, 32'hFF, 32'hFF, "w8_2s", r);
    check("w8_2s_val", r, 64'h0001);
    run_op(1'b1, 1'b1, 32'hFD, 32'd5, "w8_3a", r);
    check("w8_3a_val", r, 64'hFFF1);
    run_op(1'b1, 1'b1, 32'h80, 32'h80, "w8_3b", r);
    check("w8_3b_val", r, 64'h4000);
    run_op(1'b1, 1'b1, 32'h80, 32'h7F, "w8_3c", r);
    check("w8_3c_val", r, 64'hC080);

    // Randomized operations at both widths
    for (int i = 0; i < 24; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = $urandom;
      if (i % 6 == 5) ra = 32'h8000_0000 >> ((i % 2 == 1) ? 24 : 0);
      run_op(1'(i % 2), 1'($urandom_range(1, 0)), ra, rb, "rnd", r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_seq_n.md
Name: mult_seq_n

Overview:
Parametrised iterative shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, with a per-operation signed/unsigned mode.
- Successor to the combinational array multiplier. Trades one adder's area for WIDTH+2 cycles of latency.
- Sits beside the ALU and is driven by the control unit for MUL/MULU.
- Result is held on HI/LO until the next accepted operation.

Parameters:
WIDTH, 32, operand width in bits; HI and LO are WIDTH each; must be >= 2.
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden).

Ports:
CLK     input   1      clock; all state changes on rising edge
RST     input   1      synchronous, active-low reset
START   input   1      request; sampled only while BUSY=0
SIGNED  input   1      1 = two's-complement operands/result, 0 = unsigned; sampled with START
A       input   WIDTH  multiplicand; sampled with START
B       input   WIDTH  multiplier; sampled with START
HI      output  WIDTH  upper half of product (registered)
LO      output  WIDTH  lower half of product (registered)
BUSY    output  1      high from the accept edge until the result edge
DONE    output  1      one-cycle pulse; HI/LO valid from this cycle onward

Behaviour:
- Reset: an edge with RST=0 forces state IDLE, HI=0, LO=0, BUSY=0, DONE=0, and clears all internal registers.
  - Reset mid-operation aborts the operation; no DONE is produced.
- States: IDLE, RUN, FIX.
- IDLE:
  - DONE=0 except in the single cycle after FIX.
  - At an edge with START=1, capture operands:
    - mcnd = |A| and mplr = |B| when SIGNED=1; raw A and B when SIGNED=0.
    - neg = SIGNED & (A[W-1]^B[W-1]).
    - acc = {WIDTH'b0, mplr}, cnt = 0.
  - Go to RUN, BUSY=1.
- RUN, one iteration per edge:
  - sum = acc[2W-1:W] + (acc[0] ? mcnd : 0), computed at WIDTH+1 bits including the carry.
  - acc <= {sum, acc[W-1:1]}; cnt <= cnt+1.
  - After the WIDTH-th iteration (cnt == WIDTH-1 at that edge), go to FIX.
- FIX, one edge:
  - {HI,LO} <= neg ? -acc : acc, as a 2W-bit two's complement.
  - DONE <= 1, BUSY <= 0, state <= IDLE.
- Latency: START accepted at edge k -> RUN edges k+1..k+WIDTH -> FIX edge k+WIDTH+1 -> DONE high during the cycle after edge k+WIDTH+1.
  - Total of WIDTH+2 edges from accept to DONE assertion.
- Magnitude of the most negative operand (2^(W-1)) fits in WIDTH unsigned bits; no overflow in any case.
  - -2^(W-1) * -2^(W-1) = 2^(2W-2) is representable in 2W signed bits.
- START while BUSY=1 is ignored: not queued, and operands are not re-sampled.
- START at the same edge DONE is driven (the FIX edge): ignored, because BUSY is still 1 at that edge.
- START in the DONE cycle is accepted. BUSY rises, and HI/LO keep the previous result until the new FIX edge.
- HI/LO change only at FIX edges and at reset.
- A/B/SIGNED may change freely after accept.
- Operands of 0 take full latency; there is no early termination.

Decomposition:
- Shared package/header:
  - State encoding constants (ST_IDLE=2'b00, ST_RUN=2'b01, ST_FIX=2'b10).
  - Default WIDTH constant (matches data-path width definition).
- One natural sub-module: twos_neg_n (parameter WIDTH; inputs EN, D; output Q = EN ? ~D+1 : D; purely combinational).
  - Instantiated twice at WIDTH for operand magnitudes.
  - Instantiated once at 2*WIDTH for the result fix-up.
- Accumulator, counter and FSM stay in mult_seq_n.

Test Plan:
1. WIDTH=32, SIGNED=0, A=7, B=6, START for one cycle at edge k -> BUSY=1 edges k..k+33; DONE=1 exactly in the cycle after edge k+33; HI=0x00000000, LO=0x0000002A.
2. SIGNED=0, A=B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. Then SIGNED=1 with the same operands -> HI=0x00000000, LO=0x00000001.
3. SIGNED=1, A=0xFFFFFFFD (-3), B=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1. Then A=B=0x80000000 -> HI=0x40000000, LO=0x00000000.
4. Start 3x4; pulse START with A=9, B=9 at the 10th RUN cycle -> result HI=0, LO=0x0C; exactly one DONE; the second request is never executed.
5. Start 5x5; assert RST=0 for one edge at the 5th RUN cycle -> next cycle HI=LO=0, BUSY=0, DONE=0. No DONE follows; a fresh 2x3 then yields LO=6.
6. Back-to-back: START=1 in the DONE cycle of the 7x6 op with A=2, B=8 -> HI/LO hold 0x2A until the new DONE, then LO=0x10. Repeat scenarios 1-3 with WIDTH=8 (e.g. signed 0x80*0x80 -> HI=0x40, LO=0x00, latency 10).
